// File: rtl/spi_sample_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sample_arbiter
//  Purpose  : Shares the single DATA_W-bit SPI_to_USB output word among
//             NUM_CH sample sources. Each source owns a one-deep holding
//             register. A round-robin scheduler presents the next pending
//             sample on data1 with a one-cycle new_Data strobe. It then
//             follows the host chip select to learn when that word has been
//             shifted out.
//  Ports    : clk          system clock (8 MHz)
//             rst          asynchronous active-high reset
//             ch_data      packed samples, channel i at [i*DATA_W +: DATA_W]
//             ch_valid     per-channel single-cycle capture strobe
//             cs           raw SPI chip select, active-low, asynchronous
//             clr_overrun  clears the sticky overrun flags
//             data1        word presented to SPI_to_USB
//             new_Data     one-cycle strobe marking a new data1 value
//             out_chan     channel index of the current data1
//             busy         high whenever the scheduler is not idle
//             overrun      sticky per-channel overwrite flags
//             drop_cnt     (only with ARB_DROP_CNT_EN) saturating count of
//                          overwrites plus abandoned words
//  Options  : define ARB_DROP_CNT_EN to add the drop_cnt output
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sample_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 12,
   parameter int CH_W    = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic                     cs,
   input  logic                     clr_overrun,
   output logic [DATA_W-1:0]        data1,
   output logic                     new_Data,
   output logic [CH_W-1:0]          out_chan,
   output logic                     busy,
   output logic [NUM_CH-1:0]        overrun
`ifdef ARB_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int              c_tmo_w    = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   localparam logic [CH_W:0]   c_num_ch   = (CH_W+1)'(NUM_CH);
   localparam logic [CH_W-1:0] c_last_ch  = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ARMED = 2'd2,
      S_XFER  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_cs_meta;
   logic                r_cs_s;

   logic [DATA_W-1:0]   r_hold [NUM_CH];
   logic [NUM_CH-1:0]   r_pending;
   logic [CH_W-1:0]     r_rr_ptr;
   logic [CH_W-1:0]     r_grant_ch;
   logic [DATA_W-1:0]   r_grant_data;
   logic [c_tmo_w-1:0]  r_tmo_cnt;

   logic                w_any;
   logic [CH_W-1:0]     w_gnt;
   logic [CH_W:0]       w_sum;
   logic                w_grant;
   logic                w_tmo_hit;
   logic [NUM_CH-1:0]   w_sel;
   logic [NUM_CH-1:0]   w_ovw;

   // ---------------------------------------------------------------------
   // cs synchroniser; preset high so a reset never looks like a frame start
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_meta <= 1'b1;
         r_cs_s    <= 1'b1;
      end else begin
         r_cs_meta <= cs;
         r_cs_s    <= r_cs_meta;
      end
   end

   // ---------------------------------------------------------------------
   // Round-robin search: first pending channel at or after r_rr_ptr
   // ---------------------------------------------------------------------
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_sum = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
         if (w_sum >= c_num_ch) begin
            w_sum = w_sum - c_num_ch;
         end
         if (!w_any && r_pending[w_sum[CH_W-1:0]]) begin
            w_any = 1'b1;
            w_gnt = w_sum[CH_W-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_grant     = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_ARMED;
         end
         S_ARMED: begin
            // A host already mid-frame counts: that frame carries the word
            if (!r_cs_s) begin
               w_state_nxt = S_XFER;
            end else if (r_tmo_cnt == c_tmo_last) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_XFER: begin
            if (r_cs_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // ---------------------------------------------------------------------
   // Grant staging and output word. The granted word is copied out of its
   // holding register at grant time so a capture on the same edge cannot
   // replace it before LOAD publishes it.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_ch   <= '0;
         r_grant_data <= '0;
         r_rr_ptr     <= '0;
         r_tmo_cnt    <= '0;
         data1        <= '0;
         out_chan     <= '0;
         new_Data     <= 1'b0;
      end else begin
         new_Data <= (r_state == S_LOAD);
         if (w_grant) begin
            r_grant_ch   <= w_gnt;
            r_grant_data <= r_hold[w_gnt];
            r_rr_ptr     <= (w_gnt == c_last_ch) ? '0 : w_gnt + 1'b1;
         end
         if (r_state == S_LOAD) begin
            data1     <= r_grant_data;
            out_chan  <= r_grant_ch;
            r_tmo_cnt <= '0;
         end else if ((r_state == S_ARMED) && r_cs_s && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Holding registers, pending and overrun flags
   // ---------------------------------------------------------------------
   assign w_sel = w_grant ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_gnt) : '0;
   // A capture onto a still-pending sample is an overwrite, unless that
   // sample is leaving through a grant on the same edge.
   assign w_ovw = ch_valid & r_pending & ~w_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_hold[i] <= '0;
         end
         r_pending <= '0;
         overrun   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i]) begin
               r_hold[i] <= ch_data[i*DATA_W +: DATA_W];
            end
         end
         r_pending <= ch_valid | (r_pending & ~w_sel);
         overrun   <= w_ovw | (clr_overrun ? '0 : overrun);
      end
   end

`ifdef ARB_DROP_CNT_EN
   // ---------------------------------------------------------------------
   // Drop counter: overwrites plus abandoned words, saturating
   // ---------------------------------------------------------------------
   logic [4:0]  w_drop_inc;
   logic [15:0] w_drop_base;
   logic [16:0] w_drop_sum;

   always_comb begin
      w_drop_inc = {4'd0, w_tmo_hit};
      for (int i = 0; i < NUM_CH; i++) begin
         w_drop_inc = w_drop_inc + {4'd0, w_ovw[i]};
      end
      w_drop_base = clr_overrun ? 16'd0 : drop_cnt;
      w_drop_sum  = {1'b0, w_drop_base} + {12'd0, w_drop_inc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= 16'd0;
      end else begin
         drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_sample_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_sample_arbiter
//  Purpose  : Self-checking bench for spi_sample_arbiter. Directed scenarios
//             (single sample, round-robin, overrun, timeout, grant/capture
//             collision, async reset) followed by randomized rounds checked
//             against a transaction-level model of the holding registers and
//             the round-robin order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sample_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 12;
   localparam int CW  = 2;
   localparam int TMO = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_valid;
   logic              cs;
   logic              clr_overrun;
   logic [DW-1:0]     data1;
   logic              new_Data;
   logic [CW-1:0]     out_chan;
   logic              busy;
   logic [NCH-1:0]    overrun;
`ifdef ARB_DROP_CNT_EN
   logic [15:0]       drop_cnt;
`endif

   spi_sample_arbiter #(
      .NUM_CH (NCH),
      .DATA_W (DW),
      .CH_W   (CW),
      .TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .cs         (cs),
      .clr_overrun(clr_overrun),
      .data1      (data1),
      .new_Data   (new_Data),
      .out_chan   (out_chan),
      .busy       (busy),
      .overrun    (overrun)
`ifdef ARB_DROP_CNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: what each channel holds, what is waiting, where the
   // round-robin search starts, and the word currently expected on data1.
   bit          m_pend [NCH];
   logic [11:0] m_hold [NCH];
   int          m_ptr;
   logic [3:0]  m_ovr;
   int          m_drops;
   int          exp_ch;
   logic [11:0] exp_w;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) begin
         m_pend[i] = 1'b0;
         m_hold[i] = '0;
      end
      m_ptr   = 0;
      m_ovr   = '0;
      m_drops = 0;
      exp_ch  = 0;
      exp_w   = '0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      ch_valid    = '0;
      ch_data     = '0;
      cs          = 1'b1;
      clr_overrun = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_clear();
   endtask

   // Drives one capture cycle; returns at the negedge after it was sampled.
   task automatic strobe(input logic [3:0] mask, input logic [47:0] data);
      ch_valid = mask;
      ch_data  = data;
      for (int i = 0; i < NCH; i++) begin
         if (mask[i]) begin
            if (m_pend[i]) begin
               m_ovr[i] = 1'b1;
               m_drops++;
            end
            m_pend[i] = 1'b1;
            m_hold[i] = data[i*DW +: DW];
         end
      end
      step();
      ch_valid = '0;
   endtask

   // Next grant by round-robin order from the model's pointer.
   task automatic model_grant(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         int idx;
         idx = (m_ptr + k) % NCH;
         if (!ok && m_pend[idx]) begin
            ok        = 1'b1;
            exp_ch    = idx;
            exp_w     = m_hold[idx];
            m_pend[idx] = 1'b0;
            m_ptr     = (idx + 1) % NCH;
         end
      end
   endtask

   task automatic wait_word(input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < TMO + 32 && !seen; n++) begin
         step();
         if (new_Data === 1'b1) seen = 1'b1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_data"}, 32'(data1), 32'(exp_w));
         check({tag, "_chan"}, 32'(out_chan), 32'(exp_ch));
      end
   endtask

   // One host frame; called at the negedge on which new_Data was seen.
   task automatic frame(input int low_cycles, input bit rnd);
      logic [63:0] r64;
      cs = 1'b0;
      step();
      check("nd_one_cycle", 32'(new_Data), 32'd0);
      for (int n = 0; n < low_cycles; n++) begin
         if (rnd && $urandom_range(0, 1) == 1) begin
            r64 = {$urandom(), $urandom()};
            strobe(4'($urandom_range(0, 15)), r64[47:0]);
         end else begin
            step();
         end
      end
      check("data_stable_cs_low", 32'(data1), 32'(exp_w));
      cs = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit          ok;
      int          nd_count;
      logic [63:0] r64;

      rst = 1'b1;
      cs  = 1'b1;
      ch_valid = '0;
      ch_data = '0;
      clr_overrun = 1'b0;
      do_reset();

      // ---------------- reset values ----------------
      check("rst_data1",    32'(data1),    32'd0);
      check("rst_new_Data", 32'(new_Data), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_overrun",  32'(overrun),  32'd0);
`ifdef ARB_DROP_CNT_EN
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

      // ---------------- single sample, exact latency ----------------
      strobe(4'b0100, {12'h000, 12'hABC, 24'h0});
      check("t1_nd_edgeN",  32'(new_Data), 32'd0);
      model_grant(ok);
      step();
      check("t1_nd_edgeN1", 32'(new_Data), 32'd0);
      step();
      check("t1_nd_edgeN2", 32'(new_Data), 32'd1);
      check("t1_data1",     32'(data1),    32'hABC);
      check("t1_out_chan",  32'(out_chan), 32'd2);
      step();
      check("t1_nd_edgeN3", 32'(new_Data), 32'd0);
      cs = 1'b0;
      repeat (4) step();
      check("t1_busy_xfer", 32'(busy), 32'd1);
      cs = 1'b1;
      repeat (4) step();
      check("t1_busy_done", 32'(busy), 32'd0);

      // ---------------- round-robin ----------------
      do_reset();
      strobe(4'b1111, {12'h004, 12'h003, 12'h002, 12'h001});
      for (int r = 0; r < NCH; r++) begin
         model_grant(ok);
         wait_word("rr");
         check("rr_chan_order", 32'(out_chan), 32'(r));
         check("rr_data_order", 32'(data1),    32'(r + 1));
         frame(4, 1'b0);
      end
      repeat (4) step();
      check("rr_busy_done", 32'(busy),    32'd0);
      check("rr_overrun",   32'(overrun), 32'd0);

      // ---------------- overrun ----------------
      do_reset();
      strobe(4'b1000, {12'h333, 36'h0});
      model_grant(ok);
      wait_word("ov_first");
      cs = 1'b0;
      repeat (3) step();
      strobe(4'b0001, {36'h0, 12'h111});
      strobe(4'b0001, {36'h0, 12'h222});
      check("ov_flag",       32'(overrun), 32'h1);
      check("ov_flag_model", 32'(overrun), 32'(m_ovr));
      cs = 1'b1;
      model_grant(ok);
      wait_word("ov_ch0");
      check("ov_ch0_data", 32'(data1), 32'h222);
      frame(4, 1'b0);
      repeat (4) step();
`ifdef ARB_DROP_CNT_EN
      check("ov_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      m_ovr   = '0;
      m_drops = 0;
      check("ov_cleared", 32'(overrun), 32'd0);
`ifdef ARB_DROP_CNT_EN
      check("ov_drop_cleared", 32'(drop_cnt), 32'd0);
`endif

      // ---------------- timeout ----------------
      do_reset();
      strobe(4'b0100, {12'h000, 12'h5A5, 24'h0});
      model_grant(ok);
      step();
      step();
      check("to_nd", 32'(new_Data), 32'd1);
      repeat (TMO - 1) step();
      check("to_busy_before", 32'(busy), 32'd1);
      step();
      check("to_busy_after", 32'(busy), 32'd0);
      check("to_data_kept",  32'(data1), 32'h5A5);
      m_drops++;
`ifdef ARB_DROP_CNT_EN
      check("to_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif

      // ---------------- grant / capture collision ----------------
      do_reset();
      strobe(4'b0011, {24'h0, 12'h0B1, 12'h0A0});
      model_grant(ok);
      wait_word("col_ch0");
      cs = 1'b0;
      repeat (4) step();
      cs = 1'b1;
      repeat (3) step();
      // ch1 is granted on the next edge; capture a new ch1 word on it
      model_grant(ok);
      strobe(4'b0010, {24'h0, 12'h0C1, 12'h0});
      step();
      check("col_nd",    32'(new_Data), 32'd1);
      check("col_old",   32'(data1),    32'h0B1);
      check("col_chan",  32'(out_chan), 32'd1);
      check("col_ovr",   32'(overrun),  32'd0);
      check("col_model", 32'(data1),    32'(exp_w));
      frame(4, 1'b0);
      model_grant(ok);
      wait_word("col_new");
      check("col_new_data", 32'(data1), 32'h0C1);
      frame(4, 1'b0);
      repeat (4) step();
      check("col_busy_done", 32'(busy),    32'd0);
      check("col_ovr_end",   32'(overrun), 32'd0);

      // ---------------- async reset mid-transfer ----------------
      do_reset();
      strobe(4'b0001, {36'h0, 12'h777});
      model_grant(ok);
      wait_word("ar_first");
      cs = 1'b0;
      repeat (3) step();
      strobe(4'b0110, {12'h0, 12'h666, 12'h555, 12'h0});
      strobe(4'b0010, {24'h0, 12'h999, 12'h0});
      #2;
      rst = 1'b1;
      #1;
      check("ar_data1",    32'(data1),    32'd0);
      check("ar_new_Data", 32'(new_Data), 32'd0);
      check("ar_out_chan", 32'(out_chan), 32'd0);
      check("ar_busy",     32'(busy),     32'd0);
      check("ar_overrun",  32'(overrun),  32'd0);
      cs = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_clear();
      nd_count = 0;
      for (int n = 0; n < 30; n++) begin
         step();
         if (new_Data === 1'b1) nd_count++;
      end
      check("ar_no_new_Data", 32'(nd_count), 32'd0);
      check("ar_busy_after",  32'(busy),     32'd0);

      // ---------------- randomized rounds ----------------
      for (int rnd = 0; rnd < 8; rnd++) begin
         r64 = {$urandom(), $urandom()};
         strobe(4'($urandom_range(1, 15)), r64[47:0]);
         model_grant(ok);
         while (ok) begin
            wait_word("rnd");
            if ($urandom_range(0, 3) == 0) begin
               m_drops++;   // host never answers: word times out
            end else begin
               frame($urandom_range(3, 8), 1'b1);
            end
            model_grant(ok);
         end
         repeat (TMO + 4) step();
         check("rnd_busy_done", 32'(busy),    32'd0);
         check("rnd_overrun",   32'(overrun), 32'(m_ovr));
`ifdef ARB_DROP_CNT_EN
         check("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
         clr_overrun = 1'b1;
         step();
         clr_overrun = 1'b0;
         m_ovr   = '0;
         m_drops = 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_sample_arbiter.md
Name: spi_sample_arbiter

Overview:
- Shares the single 12-bit SPI_to_USB output channel among NUM_CH optical-sensor sample sources.
- Each source gets a one-deep holding register. A round-robin scheduler picks the next pending sample and presents it on data1 with a one-cycle new_Data strobe.
- The scheduler then tracks the SPI master's cs to learn when that word has been shifted out.
- Sits between the ADC front-end capture blocks and SPI_to_USB, in the clk (8 MHz system) domain.

Parameters:
- NUM_CH, 4, number of sample sources (2..8).
- DATA_W, 12, sample width; matches the SPI_to_USB data1 width.
- CH_W, 2, width of the channel index; must satisfy 2^CH_W >= NUM_CH.
- TIMEOUT, 4096, clk cycles to wait in ARMED for cs to assert before abandoning the word.

Ports:
- clk  in  1  system clock (8 MHz).
- rst  in  1  asynchronous active-high reset.
- ch_data  in  NUM_CH*DATA_W  packed samples; channel i occupies [i*DATA_W +: DATA_W].
- ch_valid  in  NUM_CH  single-cycle capture strobe per channel.
- cs  in  1  raw SPI chip select from the host, active-low, asynchronous to clk.
- clr_overrun  in  1  clears the overrun flags.
- data1  out  DATA_W  word presented to SPI_to_USB.
- new_Data  out  1  one-cycle strobe marking a new data1 value.
- out_chan  out  CH_W  channel index of the current data1.
- busy  out  1  high when the state is not IDLE.
- overrun  out  NUM_CH  sticky per-channel overwrite flags.

Behaviour:
- Reset values (asynchronous):
  - data1=0, new_Data=0, out_chan=0, busy=0, overrun=0.
  - All pending bits=0, rr_ptr=0, state=IDLE.
  - cs synchroniser preset to 1; timeout counter=0.
- cs is passed through a 2-FF synchroniser. All state logic uses only the synchronised value cs_s.
- Holding registers:
  - ch_valid[i] loads hold[i] from ch_data and sets pending[i].
  - If pending[i] is already set and channel i is not being granted that cycle, the new sample overwrites the old one and overrun[i] is set.
  - If ch_valid[i] coincides with a grant of channel i, the granted word is the old hold[i]. The new sample is captured, pending[i] stays 1, and no overrun is flagged.
- clr_overrun clears all overrun bits. An overrun event in the same cycle takes priority, so that bit stays set.
- Arbitration:
  - Round-robin search starts at rr_ptr and wraps from NUM_CH-1 to 0.
  - After granting channel g, rr_ptr becomes (g+1) mod NUM_CH.
- FSM:
  - IDLE: if any pending bit is set, grant channel g, clear pending[g], go to LOAD.
  - LOAD: register data1=hold[g] and out_chan=g; assert new_Data for exactly this one cycle; reset the timeout counter; go to ARMED.
  - ARMED: if cs_s==0, go to XFER. Otherwise increment the timeout counter; when it reaches TIMEOUT-1, go to IDLE (word abandoned, data1 left unchanged).
  - XFER: wait for cs_s==1 (frame end), then go to IDLE.
- Latency:
  - From ch_valid sampled at edge N with the FSM idle, new_Data is high during the cycle after edge N+2.
  - Back-to-back grants are separated by at least one complete cs low/high frame or one timeout.
- data1 and out_chan hold their values until the next LOAD and never change while cs_s is low.
- If cs_s is already low on entering ARMED (host mid-frame), the FSM goes to XFER and the word is considered sent at that frame's end. This matches SPI_to_USB, which latches data1 on new_Data.
- Reset mid-operation: the FSM aborts immediately to IDLE and all pending samples are discarded.

Optional Feature:
- Macro: ARB_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits, reset value 0.
  - Counts every overwrite event across all channels; k channels overwriting in the same cycle add k.
  - Also counts every ARMED timeout.
  - Saturates at 16'hFFFF; cleared by clr_overrun.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single sample: reset, then ch_valid=4'b0100 with ch_data[35:24]=12'hABC. Required: new_Data pulses once 2 cycles later, data1=12'hABC, out_chan=2. After cs goes low then high, busy=0.
- Round-robin: all four channels valid in the same cycle with values 0x001..0x004. Host runs four cs frames. Required: out_chan sequence 0,1,2,3 with matching data1; no overrun.
- Overrun: ch0 strobed with 0x111 then 0x222 while the FSM waits in XFER on another channel. Required: overrun[0]=1 and the next ch0 grant has data1=0x222. Then pulse clr_overrun; required: overrun=0.
- Timeout: grant a sample with cs held at 1. Required: busy drops exactly TIMEOUT cycles after ARMED entry; with ARB_DROP_CNT_EN defined, drop_cnt increments by 1.
- Grant/capture collision: ch_valid[1] in the same cycle that ch1 is granted. Required: the old word is sent, pending[1] stays set, the new word is sent next, no overrun.
- Async reset: assert rst while in XFER with two channels pending. Required: all outputs return to reset values immediately and no further new_Data appears after rst is released.
